// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: FSM states, frame size, line idle level.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int   DATA_BITS = 8;
    // A UART-style line rests high between frames.
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit, reset to a chosen level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, loads RST_VAL into both flops
//   d    - asynchronous input
//   q    - synchronised output
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_sampler.sv
// Oversampling 8N1 serial receiver with selectable input polarity and framing-error detection.
// Latency: data_valid/frame_err pulse 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT edges after the start edge.
// Backpressure: none; a byte is presented for one cycle and must be taken then.
//
// Ports:
//   clk        - core clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   rx_in      - raw serial line, asynchronous to clk
//   data_out   - last correctly framed byte (held until the next good frame)
//   data_valid - one-cycle pulse when data_out updates
//   frame_err  - one-cycle pulse when the stop bit samples low
//   busy       - high whenever the receiver is not idle
// CLKS_PER_BIT must be even and at least 4.
`timescale 1ns/1ps
module serial_rx_sampler
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit INVERT       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_norm;
    logic                 rx_sync;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // Polarity fix happens before synchronisation so the flops' reset value
    // matches the idle level seen by the FSM regardless of INVERT.
    assign rx_norm = rx_in ^ INVERT;

    sync_2ff #(
        .RST_VAL (LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_norm),
        .q   (rx_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (rx_sync != LINE_IDLE) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    // Re-check the start bit at its midpoint; anything shorter
                    // than half a bit is treated as line noise.
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_sync != LINE_IDLE) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    // cnt was aligned to the start-bit midpoint, so a full bit
                    // period later lands on the middle of each data bit.
                    if (cnt == CNT_END) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (cnt == CNT_END) begin
                        cnt <= '0;
                        if (rx_sync == LINE_IDLE) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end

                BREAK: begin
                    // Hold off start detection until the line has gone idle,
                    // so a held-low line does not spawn a stream of bad frames.
                    if (rx_sync == LINE_IDLE) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_sampler.sv
`timescale 1ns/1ps
module tb_serial_rx_sampler;

    localparam int N      = 16;
    localparam int BIT_NS = N * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;   // non-inverting receiver: pin idles high
    logic       rx1 = 1'b0;   // inverting receiver: pin idles low

    logic [7:0] data_out0, data_out1;
    logic       data_valid0, data_valid1;
    logic       frame_err0, frame_err1;
    logic       busy0, busy1;

    int errors = 0;
    int checks = 0;

    int         cyc        = 0;
    int         vld0       = 0;
    int         vld1       = 0;
    int         err0       = 0;
    int         err1       = 0;
    int         busy_cyc0  = 0;
    int         hit3c0     = 0;
    int         vld_cyc0   = 0;
    logic [7:0] last_data0 = 8'h00;
    logic [7:0] prev_data0 = 8'h00;
    logic [7:0] last_data1 = 8'h00;

    serial_rx_sampler #(.CLKS_PER_BIT(N), .INVERT(1'b0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx0),
        .data_out   (data_out0),
        .data_valid (data_valid0),
        .frame_err  (frame_err0),
        .busy       (busy0)
    );

    serial_rx_sampler #(.CLKS_PER_BIT(N), .INVERT(1'b1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx1),
        .data_out   (data_out1),
        .data_valid (data_valid1),
        .frame_err  (frame_err1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running event counters; tests take before/after snapshots.
    always @(negedge clk) begin
        if (data_valid0) begin
            vld0       <= vld0 + 1;
            vld_cyc0   <= cyc;
            prev_data0 <= last_data0;
            last_data0 <= data_out0;
            if (data_out0 == 8'h3C) hit3c0 <= hit3c0 + 1;
        end
        if (frame_err0) err0 <= err0 + 1;
        if (busy0) busy_cyc0 <= busy_cyc0 + 1;
        if (data_valid1) begin
            vld1       <= vld1 + 1;
            last_data1 <= data_out1;
        end
        if (frame_err1) err1 <= err1 + 1;
    end

    task automatic set_pin(input logic sel, input logic v);
        if (sel) rx1 = v;
        else     rx0 = v;
    endtask

    // Drives start, 8 data bits LSB first, stop. pin_inv flips every level at the pin.
    task automatic drive_frame(input logic sel, input logic [7:0] b, input logic stop_bit,
                               input logic pin_inv, input int bit_ns, input logic align,
                               output int start_cyc);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        if (align) begin
            @(posedge clk);
            #1;
        end
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            set_pin(sel, frame[i] ^ pin_inv);
            #(bit_ns);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_out0 !== 8'h00) begin errors++; $display("FAIL rst_data0: got %h want 00", data_out0); end
        checks++; if (data_valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid0: got %b want 0", data_valid0); end
        checks++; if (frame_err0 !== 1'b0) begin errors++; $display("FAIL rst_ferr0: got %b want 0", frame_err0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy0: got %b want 0", busy0); end
        checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL rst_data1: got %h want 00", data_out1); end
        checks++; if (data_valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %b want 0", data_valid1); end
        checks++; if (frame_err1 !== 1'b0) begin errors++; $display("FAIL rst_ferr1: got %b want 0", frame_err1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy1: got %b want 0", busy1); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy0: got %b want 0", busy0); end
    endtask

    task automatic test_a5;
        int sc, v, e;
        v = vld0; e = err0;
        drive_frame(1'b0, 8'hA5, 1'b1, 1'b0, BIT_NS, 1'b1, sc);
        #100;
        checks++; if (vld0 - v !== 1) begin errors++; $display("FAIL a5_count: got %0d want 1", vld0 - v); end
        checks++; if (data_out0 !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", data_out0); end
        checks++; if (vld_cyc0 - sc !== 155) begin errors++; $display("FAIL a5_latency: got edge k+%0d want k+154", vld_cyc0 - sc - 1); end
        checks++; if (err0 - e !== 0) begin errors++; $display("FAIL a5_ferr: got %0d want 0", err0 - e); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL a5_busy: got %b want 0", busy0); end
    endtask

    task automatic test_frame_err;
        int sc, v, e;
        v = vld0; e = err0;
        drive_frame(1'b0, 8'h00, 1'b0, 1'b0, BIT_NS, 1'b1, sc);
        #400;
        checks++; if (err0 - e !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", err0 - e); end
        checks++; if (vld0 - v !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", vld0 - v); end
        checks++; if (data_out0 !== 8'hA5) begin errors++; $display("FAIL ferr_hold: got %h want a5", data_out0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b want 1", busy0); end
        rx0 = 1'b1;
        #50;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ferr_break_exit: got %b want 0", busy0); end
        checks++; if (err0 - e !== 1) begin errors++; $display("FAIL ferr_single: got %0d want 1", err0 - e); end
        drive_frame(1'b0, 8'h81, 1'b1, 1'b0, BIT_NS, 1'b1, sc);
        #100;
        checks++; if (vld0 - v !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", vld0 - v); end
        checks++; if (data_out0 !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h want 81", data_out0); end
    endtask

    task automatic test_glitch;
        int v, e, b;
        v = vld0; e = err0; b = busy_cyc0;
        @(posedge clk);
        #1;
        rx0 = 1'b0;
        #30;
        rx0 = 1'b1;
        #300;
        checks++; if ((busy_cyc0 - b) < 1 || (busy_cyc0 - b) > N / 2 + 1) begin
            errors++; $display("FAIL glitch_busy_len: got %0d cycles want 1..%0d", busy_cyc0 - b, N / 2 + 1);
        end
        checks++; if (vld0 - v !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", vld0 - v); end
        checks++; if (err0 - e !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", err0 - e); end
        checks++; if (data_out0 !== 8'h81) begin errors++; $display("FAIL glitch_hold: got %h want 81", data_out0); end
    endtask

    task automatic test_back_to_back;
        int sc, v, e;
        v = vld0; e = err0;
        drive_frame(1'b0, 8'h55, 1'b1, 1'b0, 165, 1'b1, sc);
        drive_frame(1'b0, 8'hFF, 1'b1, 1'b0, 165, 1'b0, sc);
        #200;
        checks++; if (vld0 - v !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", vld0 - v); end
        checks++; if (prev_data0 !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h want 55", prev_data0); end
        checks++; if (last_data0 !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", last_data0); end
        checks++; if (err0 - e !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", err0 - e); end
    endtask

    task automatic test_invert;
        int sc, v, e, h;
        v = vld1; e = err1;
        drive_frame(1'b1, 8'h3C, 1'b1, 1'b1, BIT_NS, 1'b1, sc);
        #100;
        checks++; if (vld1 - v !== 1) begin errors++; $display("FAIL inv_count: got %0d want 1", vld1 - v); end
        checks++; if (data_out1 !== 8'h3C) begin errors++; $display("FAIL inv_data: got %h want 3c", data_out1); end
        checks++; if (err1 - e !== 0) begin errors++; $display("FAIL inv_ferr: got %0d want 0", err1 - e); end
        // Same inverted waveform into the non-inverting receiver must never yield 0x3C.
        h = hit3c0;
        rx0 = 1'b0;
        #(2 * BIT_NS);
        drive_frame(1'b0, 8'h3C, 1'b1, 1'b1, BIT_NS, 1'b0, sc);
        #(2 * BIT_NS);
        rx0 = 1'b1;
        #(25 * BIT_NS);
        checks++; if (hit3c0 - h !== 0) begin errors++; $display("FAIL noinv_3c: got %0d hits want 0", hit3c0 - h); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL noinv_recover: got %b want 0", busy0); end
    endtask

    task automatic test_reset_midframe;
        int sc, v;
        fork
            drive_frame(1'b0, 8'hF0, 1'b1, 1'b0, BIT_NS, 1'b1, sc);
            begin
                @(posedge clk);
                #(1 + 5 * BIT_NS + BIT_NS / 2);
                checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy0); end
                rst = 1'b1;
                #2;
                checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy0); end
                checks++; if (data_out0 !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", data_out0); end
                checks++; if (data_valid0 !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", data_valid0); end
                checks++; if (frame_err0 !== 1'b0) begin errors++; $display("FAIL mid_ferr: got %b want 0", frame_err0); end
                #20;
                rst = 1'b0;
            end
        join
        v = vld0;
        #(2 * BIT_NS);
        checks++; if (vld0 - v !== 0) begin errors++; $display("FAIL mid_discard: got %0d want 0", vld0 - v); end
        drive_frame(1'b0, 8'h12, 1'b1, 1'b0, BIT_NS, 1'b1, sc);
        #100;
        checks++; if (vld0 - v !== 1) begin errors++; $display("FAIL mid_next_count: got %0d want 1", vld0 - v); end
        checks++; if (data_out0 !== 8'h12) begin errors++; $display("FAIL mid_next_data: got %h want 12", data_out0); end
    endtask

    initial begin
        test_reset;
        test_a5;
        test_frame_err;
        test_glitch;
        test_back_to_back;
        test_invert;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
